// File: rtl/zxn_mister_pkg.sv
// Shared types and constants for the ZXN MiSTer glue logic.
// Holds the memory-clear sequencer states and the default fill pattern.
package zxn_mister_pkg;

    typedef enum logic [1:0] {
        REQ_WAIT,
        CLEAR,
        HOLD,
        IDLE
    } clr_state_t;

    localparam logic [63:0] DEFAULT_FILL = '1;

endpackage

// File: rtl/mem_clear_seq.sv
// Clears memory from address 0 to a latched end address, then holds the core
// in reset for a programmable number of cycles before releasing it.
module mem_clear_seq
    import zxn_mister_pkg::*;
#(
    parameter int              AW          = 21,
    parameter int              DW          = 8,
    parameter logic [DW-1:0]   FILL        = DEFAULT_FILL[DW-1:0],
    parameter int              N_SRC       = 4,
    parameter int              HOLD_CYCLES = 16
) (
    input  logic               clk_sys,
    input  logic               RESET,
    input  logic [N_SRC-1:0]   req,
    input  logic [AW-1:0]      end_addr,
    input  logic               mem_wait,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    output logic               mem_we,
    output logic               reset_o,
    output logic               busy,
    output logic               done
);

    clr_state_t    r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_endQ;
    logic [7:0]    r_hold;
    logic          r_we;
    logic          r_resetO;
    logic          r_busy;
    logic          r_done;

    logic          w_anyReq;
    logic          w_accept;

    assign w_anyReq = |req;
    assign w_accept = r_we & ~mem_wait;

    // Any request wins over every other transition, including the final
    // write and hold expiry, so a pending done is simply never raised.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_state  <= REQ_WAIT;
            r_addr   <= '0;
            r_endQ   <= '0;
            r_hold   <= '0;
            r_we     <= 1'b0;
            r_resetO <= 1'b1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_anyReq) begin
                r_state  <= REQ_WAIT;
                r_addr   <= '0;
                r_we     <= 1'b0;
                r_resetO <= 1'b1;
                r_busy   <= 1'b1;
            end else begin
                case (r_state)
                    REQ_WAIT: begin
                        r_endQ  <= end_addr;
                        r_addr  <= '0;
                        r_we    <= 1'b1;
                        r_state <= CLEAR;
                    end
                    CLEAR: begin
                        if (w_accept) begin
                            // Stop on the end address before incrementing so an
                            // all-ones end address never wraps back to zero.
                            if (r_addr == r_endQ) begin
                                r_we <= 1'b0;
                                if (HOLD_CYCLES == 0) begin
                                    r_state  <= IDLE;
                                    r_resetO <= 1'b0;
                                    r_busy   <= 1'b0;
                                    r_done   <= 1'b1;
                                end else begin
                                    r_state <= HOLD;
                                    r_hold  <= 8'(HOLD_CYCLES);
                                end
                            end else begin
                                r_addr <= r_addr + AW'(1);
                            end
                        end
                    end
                    HOLD: begin
                        r_hold <= r_hold - 8'd1;
                        if (r_hold <= 8'd1) begin
                            r_state  <= IDLE;
                            r_resetO <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= REQ_WAIT;
                    end
                endcase
            end
        end
    end

    assign mem_addr = r_addr;
    assign mem_din  = FILL;
    assign mem_we   = r_we;
    assign reset_o  = r_resetO;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_mem_clear_seq.sv
// Directed bench for mem_clear_seq: one instance with a 16-cycle hold and one
// with no hold, both 4-bit addressed, checked with immediate assertions.
module tb_mem_clear_seq;

    logic       clk;
    logic       RESET;
    logic [3:0] req;
    logic [3:0] endAddr;
    logic       memWait;
    logic [3:0] memAddr;
    logic [7:0] memDin;
    logic       memWe;
    logic       resetO;
    logic       busy;
    logic       done;

    logic [3:0] req0;
    logic [3:0] endAddr0;
    logic       memWait0;
    logic [3:0] memAddr0;
    logic [7:0] memDin0;
    logic       memWe0;
    logic       resetO0;
    logic       busy0;
    logic       done0;

    int nTests = 0;
    int nFail  = 0;

    logic [3:0] writeLog[$];
    int         stallCnt[16];
    int         doneCnt = 0;
    int         wr0Cnt  = 0;
    int         done0Cnt = 0;

    mem_clear_seq #(.AW(4), .DW(8), .FILL(8'hFF), .N_SRC(4), .HOLD_CYCLES(16)) dut (
        .clk_sys (clk),
        .RESET   (RESET),
        .req     (req),
        .end_addr(endAddr),
        .mem_wait(memWait),
        .mem_addr(memAddr),
        .mem_din (memDin),
        .mem_we  (memWe),
        .reset_o (resetO),
        .busy    (busy),
        .done    (done)
    );

    mem_clear_seq #(.AW(4), .DW(8), .FILL(8'hFF), .N_SRC(4), .HOLD_CYCLES(0)) dut0 (
        .clk_sys (clk),
        .RESET   (RESET),
        .req     (req0),
        .end_addr(endAddr0),
        .mem_wait(memWait0),
        .mem_addr(memAddr0),
        .mem_din (memDin0),
        .mem_we  (memWe0),
        .reset_o (resetO0),
        .busy    (busy0),
        .done    (done0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change just after the rising edge, so the falling edge sees
    // exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (memWe && !memWait) writeLog.push_back(memAddr);
        if (memWe && memWait) stallCnt[memAddr] = stallCnt[memAddr] + 1;
        if (done) doneCnt = doneCnt + 1;
        if (memWe0 && !memWait0) wr0Cnt = wr0Cnt + 1;
        if (done0) done0Cnt = done0Cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearLog();
        writeLog.delete();
        for (int i = 0; i < 16; i++) stallCnt[i] = 0;
        doneCnt = 0;
    endtask

    task automatic checkLog(input int n);
        checkOutput("nWrites", 64'(writeLog.size()), 64'(n));
        for (int i = 0; i < writeLog.size(); i++)
            checkOutput("wrAddr", 64'(writeLog[i]), 64'(i));
    endtask

    task automatic applyStimulus(input logic [3:0] lastAddr);
        endAddr = lastAddr;
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        clearLog();
    endtask

    task automatic runToDone(input int maxCycles);
        int n = 0;
        while (done !== 1'b1 && n < maxCycles) begin
            step();
            n++;
        end
        checkOutput("doneSeen", 64'(done), 64'd1);
    endtask

    task automatic runToAddr(input logic [3:0] target, input int maxCycles);
        int n = 0;
        while (!(memWe === 1'b1 && memAddr === target) && n < maxCycles) begin
            step();
            n++;
        end
        checkOutput("reachAddr", 64'(memAddr), 64'(target));
    endtask

    initial begin
        int s2;
        int s4;
        int n;
        RESET    = 1'b1;
        req      = 4'b0000;
        endAddr  = 4'd15;
        memWait  = 1'b0;
        req0     = 4'b0000;
        endAddr0 = 4'd0;
        memWait0 = 1'b0;

        // Reset state
        #3;
        checkOutput("rstAddr",   64'(memAddr), 64'd0);
        checkOutput("rstWe",     64'(memWe),   64'd0);
        checkOutput("rstDin",    64'(memDin),  64'hFF);
        checkOutput("rstResetO", 64'(resetO),  64'd1);
        checkOutput("rstBusy",   64'(busy),    64'd1);
        checkOutput("rstDone",   64'(done),    64'd0);
        step();
        step();
        RESET = 1'b0;

        // Full clear of all 16 addresses, 16 hold cycles, one done pulse
        step();
        checkOutput("dut0EntryWe", 64'(memWe0), 64'd1);
        checkOutput("dut0EntryAddr", 64'(memAddr0), 64'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 1) begin
                checkOutput("dut0Done",   64'(done0),   64'd1);
                checkOutput("dut0ResetO", 64'(resetO0), 64'd0);
                checkOutput("dut0We",     64'(memWe0),  64'd0);
                checkOutput("dut0Busy",   64'(busy0),   64'd0);
            end
            checkOutput("clrAddr", 64'(memAddr), 64'(i));
            checkOutput("clrWe",   64'(memWe),   64'd1);
            step();
        end
        checkOutput("holdWe",     64'(memWe),   64'd0);
        checkOutput("holdResetO", 64'(resetO),  64'd1);
        checkOutput("holdAddr",   64'(memAddr), 64'd15);
        for (int k = 1; k <= 15; k++) step();
        checkOutput("holdLateResetO", 64'(resetO), 64'd1);
        checkOutput("holdLateDone",   64'(done),   64'd0);
        step();
        checkOutput("endDone",   64'(done),   64'd1);
        checkOutput("endResetO", 64'(resetO), 64'd0);
        checkOutput("endBusy",   64'(busy),   64'd0);
        step();
        checkOutput("donePulse", 64'(done),    64'd0);
        checkOutput("idleAddr",  64'(memAddr), 64'd15);
        checkOutput("doneCnt",   64'(doneCnt), 64'd1);
        checkLog(16);
        checkOutput("dut0Writes", 64'(wr0Cnt),   64'd1);
        checkOutput("dut0DoneCnt", 64'(done0Cnt), 64'd1);

        // Stalls at addresses 2 and 4; late end_addr change is ignored
        applyStimulus(4'd5);
        endAddr = 4'd9;
        s2 = 0;
        s4 = 0;
        n = 0;
        while (n < 60) begin
            memWait = 1'b0;
            if (memWe && memAddr == 4'd2 && s2 < 1) begin
                memWait = 1'b1;
                s2++;
            end else if (memWe && memAddr == 4'd4 && s4 < 3) begin
                memWait = 1'b1;
                s4++;
            end
            step();
            n++;
            if (done === 1'b1) break;
        end
        memWait = 1'b0;
        checkOutput("stallDone", 64'(done), 64'd1);
        step();
        checkLog(6);
        checkOutput("stallAt2", 64'(stallCnt[2]), 64'd1);
        checkOutput("stallAt4", 64'(stallCnt[4]), 64'd3);
        checkOutput("stallDoneCnt", 64'(doneCnt), 64'd1);

        // Request pulse mid-clear restarts from address 0
        applyStimulus(4'd12);
        runToAddr(4'd9, 40);
        req = 4'b0100;
        step();
        req = 4'b0000;
        checkOutput("abortWe",     64'(memWe),   64'd0);
        checkOutput("abortAddr",   64'(memAddr), 64'd0);
        checkOutput("abortResetO", 64'(resetO),  64'd1);
        step();
        checkOutput("restartWe",   64'(memWe),   64'd1);
        checkOutput("restartAddr", 64'(memAddr), 64'd0);
        clearLog();
        runToDone(60);
        step();
        checkLog(13);
        checkOutput("abortDoneCnt", 64'(doneCnt), 64'd1);

        // Request on the final write cancels hold and done
        applyStimulus(4'd3);
        runToAddr(4'd3, 20);
        req = 4'b0001;
        step();
        req = 4'b0000;
        checkOutput("finalReqWe",   64'(memWe),   64'd0);
        checkOutput("finalReqAddr", 64'(memAddr), 64'd0);
        checkOutput("finalReqDone", 64'(done),    64'd0);
        checkOutput("finalReqBusy", 64'(busy),    64'd1);
        step();
        checkOutput("finalRestartWe", 64'(memWe), 64'd1);
        checkOutput("finalNoDone",    64'(doneCnt), 64'd0);
        clearLog();
        runToDone(40);
        step();
        checkLog(4);
        checkOutput("finalDoneCnt", 64'(doneCnt), 64'd1);

        // Asynchronous reset in the middle of HOLD
        applyStimulus(4'd2);
        step();
        step();
        step();
        checkOutput("preRstWe",   64'(memWe),   64'd0);
        checkOutput("preRstAddr", 64'(memAddr), 64'd2);
        step();
        step();
        #2 RESET = 1'b1;
        #1;
        checkOutput("asyncAddr",   64'(memAddr), 64'd0);
        checkOutput("asyncWe",     64'(memWe),   64'd0);
        checkOutput("asyncBusy",   64'(busy),    64'd1);
        checkOutput("asyncResetO", 64'(resetO),  64'd1);
        checkOutput("asyncDone",   64'(done),    64'd0);
        step();
        RESET = 1'b0;
        step();
        checkOutput("relWe",   64'(memWe),   64'd1);
        checkOutput("relAddr", 64'(memAddr), 64'd0);
        clearLog();
        runToDone(40);
        step();
        checkLog(3);
        checkOutput("relDoneCnt", 64'(doneCnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
